// File: rtl/cmp_sweep_pkg.sv
// Shared types and constants for the 2-bit comparator sweep controller.
package cmp_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    FIN
  } state_t;

  localparam int NUM_VEC = 16;
  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  localparam int GT_EXP = 6;
  localparam int EQ_EXP = 4;
  localparam int LT_EXP = 6;

  // Ideal comparator response {A>B, A==B, A<B} for a 4-bit vector index {A,B}.
  function automatic logic [2:0] exp_flags(input logic [3:0] idx);
    logic [1:0] a;
    logic [1:0] b;
    a = idx[3:2];
    b = idx[1:0];
    return {a > b, a == b, a < b};
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Settle-time countdown: load takes value, expired is high on the last of value cycles.
// expired is purely state-derived; value of 0 must be avoided by the caller.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/cmp_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a 2-bit comparator with per-category and error tallies.
// Done arrives 16*(dwell+2)+1 cycles after start; start is ignored while busy.
module cmp_sweep_ctrl
  import cmp_sweep_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         a_o,
  output logic [1:0]         b_o,
  input  logic               r_i,
  input  logic               g_i,
  input  logic               b_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [4:0]         gt_cnt,
  output logic [4:0]         eq_cnt,
  output logic [4:0]         lt_cnt,
  output logic [4:0]         err_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         idx;
  logic [DWELL_W-1:0] dwell_q;
  logic               tmr_load;
  logic               tmr_expired;
  logic [2:0]         flags;

  assign flags = {r_i, g_i, b_i};

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (dwell_q),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE: begin
        tmr_load  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (tmr_expired) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == LAST_IDX) ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      idx     <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      lt_cnt  <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            idx     <= '0;
            gt_cnt  <= '0;
            eq_cnt  <= '0;
            lt_cnt  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        SAMPLE: begin
          // A non-one-hot response counts only as an error, never as a category hit.
          if ($onehot(flags)) begin
            if (flags[2]) gt_cnt <= gt_cnt + 5'd1;
            if (flags[1]) eq_cnt <= eq_cnt + 5'd1;
            if (flags[0]) lt_cnt <= lt_cnt + 5'd1;
            if (flags != exp_flags(idx)) err_cnt <= err_cnt + 5'd1;
          end else begin
            err_cnt <= err_cnt + 5'd1;
          end
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        FIN:     pass <= (err_cnt == 5'd0);
        default: ;
      endcase
    end
  end

  assign a_o  = idx[3:2];
  assign b_o  = idx[1:0];
  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Directed bench for cmp_sweep_ctrl with a behavioural comparator that can be faulted.
module tb_cmp_sweep_ctrl;
  import cmp_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dwell;
  logic [1:0] a_o, b_o;
  logic       r_i, g_i, b_i;
  logic       busy, done, pass;
  logic [4:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
  int         mode;

  int n_chk  = 0;
  int n_fail = 0;

  cmp_sweep_ctrl #(.DWELL_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dwell   (dwell),
    .a_o     (a_o),
    .b_o     (b_o),
    .r_i     (r_i),
    .g_i     (g_i),
    .b_i     (b_i),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .gt_cnt  (gt_cnt),
    .eq_cnt  (eq_cnt),
    .lt_cnt  (lt_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // mode 0: ideal, 1: g_i stuck at 0, 2: r_i and b_i stuck at 1
  always_comb begin
    r_i = (a_o > b_o);
    g_i = (a_o == b_o);
    b_i = (a_o < b_o);
    if (mode == 1) g_i = 1'b0;
    if (mode == 2) begin
      r_i = 1'b1;
      b_i = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int gt, input int eq, input int lt,
                            input int err, input int ps);
    chk({tag, ".gt"},   int'(gt_cnt),  gt);
    chk({tag, ".eq"},   int'(eq_cnt),  eq);
    chk({tag, ".lt"},   int'(lt_cnt),  lt);
    chk({tag, ".err"},  int'(err_cnt), err);
    chk({tag, ".pass"}, int'(pass),    ps);
  endtask

  // Launches a sweep; lat = number of rising edges from the accepting edge (1) to done.
  task automatic run_sweep(input string tag, input int d, input bit noise, output int lat);
    dwell = 8'(d);
    start = 1'b1;
    lat   = -1;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 2) begin
        chk({tag, ".busy_mid"}, int'(busy), 1);
        chk({tag, ".pass_clr"}, int'(pass), 0);
      end
      if (noise && k == 20) start = 1'b1;
      if (noise && k == 30) dwell = 8'd9;
      if (done) begin
        lat = k;
        break;
      end
    end
    // In noise mode start is held across the FIN edge; it must not restart the sweep.
    start = noise;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".done_1cyc"}, int'(done), 0);
    chk({tag, ".busy_end"},  int'(busy), 0);
  endtask

  typedef struct {
    int d;
    int md;
    bit noise;
    int lat;
    int gt;
    int eq;
    int lt;
    int err;
    int ps;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;

    vecs[0] = '{d: 3,   md: 0, noise: 1'b0, lat: 81,   gt: 6, eq: 4, lt: 6, err: 0,  ps: 1};
    vecs[1] = '{d: 0,   md: 0, noise: 1'b0, lat: 49,   gt: 6, eq: 4, lt: 6, err: 0,  ps: 1};
    vecs[2] = '{d: 3,   md: 1, noise: 1'b0, lat: 81,   gt: 6, eq: 0, lt: 6, err: 4,  ps: 0};
    vecs[3] = '{d: 3,   md: 2, noise: 1'b0, lat: 81,   gt: 0, eq: 0, lt: 0, err: 16, ps: 0};
    vecs[4] = '{d: 3,   md: 0, noise: 1'b1, lat: 81,   gt: 6, eq: 4, lt: 6, err: 0,  ps: 1};
    vecs[5] = '{d: 255, md: 0, noise: 1'b0, lat: 4113, gt: 6, eq: 4, lt: 6, err: 0,  ps: 1};
    vecs[6] = '{d: 1,   md: 1, noise: 1'b0, lat: 49,   gt: 6, eq: 0, lt: 6, err: 4,  ps: 0};

    rst   = 1'b1;
    start = 1'b0;
    dwell = 8'd0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.a_o",  int'(a_o),  0);
    chk("rst.b_o",  int'(b_o),  0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk_counts("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag  = $sformatf("v%0d", i);
      mode = vecs[i].md;
      run_sweep(tag, vecs[i].d, vecs[i].noise, lat);
      chk({tag, ".latency"}, lat, vecs[i].lat);
      chk({tag, ".a_hold"}, int'(a_o), 3);
      chk({tag, ".b_hold"}, int'(b_o), 3);
      chk_counts(tag, vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].err, vecs[i].ps);
    end

    // Reset during the settle wait of vector 7 (A=1, B=3).
    mode  = 0;
    dwell = 8'd3;
    start = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("midrst.a_pre",  int'(a_o),  1);
    chk("midrst.b_pre",  int'(b_o),  3);
    chk("midrst.busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst.a_o",  int'(a_o),  0);
    chk("midrst.b_o",  int'(b_o),  0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk_counts("midrst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_sweep("post_rst", 3, 1'b0, lat);
    chk("post_rst.latency", lat, 81);
    chk_counts("post_rst", GT_EXP, EQ_EXP, LT_EXP, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_sweep_ctrl.md
CMP_SWEEP_CTRL -- requirements
Module: cmp_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter DWELL_W, default 8, giving the width of the dwell input.
REQ-003 The block SHALL have these ports, one per line:
 - clk  in  1  rising-edge clock
 - rst  in  1  asynchronous active-high reset
 - start  in  1  single-cycle request to begin a sweep
 - dwell  in  DWELL_W  settle cycles per vector; 0 is treated as 1
 - a_o  out  2  operand A driven to the 2-bit comparator
 - b_o  out  2  operand B driven to the 2-bit comparator
 - r_i  in  1  comparator flag for A>B
 - g_i  in  1  comparator flag for A==B
 - b_i  in  1  comparator flag for A<B
 - busy  out  1  high while a sweep is in progress
 - done  out  1  one-cycle pulse when a sweep completes
 - pass  out  1  high when the last sweep had zero errors; held until the next start
 - gt_cnt, eq_cnt, lt_cnt  out  5 each  count of samples whose flag was R, G or B respectively
 - err_cnt  out  5  count of mismatched or non-one-hot samples

Function
REQ-004 The FSM SHALL have the states IDLE, DRIVE, WAIT, SAMPLE and FIN.
REQ-005 In IDLE, start=1 SHALL latch the dwell value (0 becomes 1), clear the 4-bit index and all four counters, clear pass, and go to DRIVE.
REQ-006 The outputs SHALL drive a_o=index[3:2] and b_o=index[1:0] continuously, holding their values outside a sweep.
REQ-007 DRIVE SHALL last 1 cycle, load the dwell counter, and go to WAIT.
REQ-008 WAIT SHALL last exactly the latched dwell value of cycles, then go to SAMPLE.
REQ-009 SAMPLE SHALL last 1 cycle and do the following:
 - compute the expected value {a>b, a==b, a<b} from index;
 - increment gt_cnt, eq_cnt or lt_cnt according to the sampled one-hot flag;
 - increment err_cnt if {r_i,g_i,b_i} differs from expected or is not one-hot (no category counter increments in the not-one-hot case).
REQ-010 From SAMPLE, if index==15 the FSM SHALL go to FIN; otherwise it SHALL increment index and go to DRIVE.
REQ-011 FIN SHALL last 1 cycle, assert done for that cycle, set pass=(err_cnt==0) using the final count, and return to IDLE.
REQ-012 busy SHALL be 1 in DRIVE, WAIT, SAMPLE and FIN, and 0 in IDLE.
REQ-013 start SHALL be ignored while busy=1, including in FIN.
REQ-014 Sweep latency from the start edge to the done pulse SHALL be 16*(D+2)+1 cycles, where D is the latched dwell value.
REQ-015 Counters SHALL be 5 bits wide (maximum 16) and SHALL NOT wrap within a sweep.
REQ-016 Counters SHALL hold their values after FIN until the next accepted start.
REQ-017 A change on dwell during a sweep SHALL have no effect on that sweep.

Reset
REQ-018 rst=1 SHALL immediately force the following, including mid-sweep: state IDLE, index 0, a_o=b_o=0, all counters 0, busy=done=pass=0.
REQ-019 After rst deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-020 A shared package cmp_sweep_pkg SHALL hold the state enum type, NUM_VEC=16 and the expected totals: GT_EXP=6, EQ_EXP=4, LT_EXP=6.
REQ-021 The dwell countdown SHALL be a sub-module, dwell_timer, with inputs load and value and output expired.
REQ-022 The block SHALL contain no combinational path from r_i, g_i or b_i to any output.

Verification
REQ-023 Reset, dwell=3, start with an ideal comparator -> done after 81 cycles; gt=6, eq=4, lt=6, err=0, pass=1.
REQ-024 dwell=0, start -> treated as 1, done after 49 cycles; counts as in REQ-023.
REQ-025 g_i stuck at 0 -> eq=0, err=4, pass=0, gt=6, lt=6.
REQ-026 r_i and b_i both forced to 1 -> err=16, gt=lt=eq=0, pass=0.
REQ-027 start re-pulsed mid-sweep, and dwell changed to 9 mid-sweep -> both ignored; done time matches REQ-023.
REQ-028 rst pulsed during WAIT of index 7 -> all outputs 0 at once; a new start gives a full correct sweep.
